// File: rtl/uart_pkg.sv
// Shared UART constants: ASCII control bytes, byte width and the tx issue FSM encoding.
package uart_pkg;

    localparam int         UART_DATA_W = 8;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, registered read (maps onto iCE40 SB_RAM40_4K).
module fifo_ram #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_W-1:0]     rd_data
);

    logic [DATA_W-1:0] mem [0:(1 << DEPTH_LOG2) - 1];
    logic [DATA_W-1:0] rd_data_q;

    // No reset on the read register so the block stays mappable to BRAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx: pointers, level, sticky overflow and a paced IDLE/REQ/GAP issue FSM.
// Optional build macro UART_TX_FIFO_CRLF_EN expands each stored LF into CR,LF on the wire.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = UART_DATA_W,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic [DATA_W-1:0]     wr_data,
    output logic                  wr_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  tx_req,
    output logic [DATA_W-1:0]     tx_data,
    input  logic                  tx_ready,
    output tx_state_e             state_dbg
);

    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    // Handshakes: a byte is taken on any cycle with wr_req && wr_ready; wr_req without
    // wr_ready drops the byte and sets overflow. tx_req is a single-cycle pulse issued
    // only after tx_ready was seen high in IDLE; tx_ready is ignored outside IDLE.
    tx_state_e             state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_W-1:0]     tx_data_q, tx_data_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic [DATA_W-1:0]     head;
    logic [DATA_W-1:0]     send_byte;
    logic                  full, empty, push, pop;
`ifdef UART_TX_FIFO_CRLF_EN
    logic                  crlf_done_q, crlf_done_d;
`endif

    // Read address is the live head pointer, so the head is already on the RAM
    // output by the time the FSM reaches REQ.
    fifo_ram #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .DATA_W    (DATA_W)
    ) u_ram (
        .clk    (clk),
        .wr_en  (push),
        .wr_addr(wr_ptr_q),
        .wr_data(wr_data),
        .rd_addr(rd_ptr_q),
        .rd_data(head)
    );

    always_comb begin
        full       = (level_q == LVL_W'(DEPTH));
        empty      = (level_q == '0);
        push       = wr_req && !full;
        pop        = 1'b0;
        send_byte  = head;
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        tx_data_d  = tx_data_q;
`ifdef UART_TX_FIFO_CRLF_EN
        crlf_done_d = crlf_done_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!empty && tx_ready) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
`ifdef UART_TX_FIFO_CRLF_EN
                // CR is injected in front of LF without consuming an entry.
                if (head == DATA_W'(ASCII_LF) && !crlf_done_q) begin
                    send_byte   = DATA_W'(ASCII_CR);
                    crlf_done_d = 1'b1;
                end else begin
                    pop         = 1'b1;
                    crlf_done_d = 1'b0;
                end
`else
                pop = 1'b1;
`endif
                tx_data_d = send_byte;
                gap_cnt_d = '0;
                state_d   = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        wr_ptr_d   = push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        overflow_d = overflow_q || (wr_req && full);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        tx_req   = (state_q == ST_REQ);
        tx_data  = tx_req ? send_byte : tx_data_q;
        wr_ready = !full;
        level    = level_q;
        overflow = overflow_q;
        state_dbg = state_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            tx_data_q  <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

`ifdef UART_TX_FIFO_CRLF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crlf_done_q <= 1'b0;
        end else begin
            crlf_done_q <= crlf_done_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model checked every cycle plus directed scenarios.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DL    = 4;
  localparam int DW    = 8;
  localparam int GAP   = 1;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_req = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic [DL:0]   level;
  logic          overflow;
  logic          tx_req;
  logic [DW-1:0] tx_data;
  logic          tx_ready;
  tx_state_e     state_dbg;

  // clock / reset
  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH_LOG2(DL), .DATA_W(DW), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_data(wr_data), .wr_ready(wr_ready),
    .level(level), .overflow(overflow), .tx_req(tx_req), .tx_data(tx_data),
    .tx_ready(tx_ready), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // uart_tx stand-in: manual ready level, or busy for a random time after each request
  bit uart_auto = 1'b0;
  bit manual_ready = 1'b0;
  int busy = 0;
  assign tx_ready = uart_auto ? (busy == 0) : manual_ready;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!uart_auto) busy = 0;
      else if (tx_req) busy = $urandom_range(0, 8);
      else if (busy > 0) busy--;
    end
  end

  // scoreboard: stored bytes in order, sticky overflow, last byte issued
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] out_q[$];
  int            req_cyc_q[$];
  bit            ovf_m = 1'b0;
  bit            cr_sent_m = 1'b0;
  logic [DW-1:0] last_tx_m = '0;
  bit            prev_ready = 1'b0;
  bit            prev_req = 1'b0;
  int            cyc = 0;
  int            last_req_cyc = -100;
  int            req_cnt = 0;
  int            max_level = 0;

  always @(negedge clk) begin
    logic [DW-1:0] e;
    bit full_m;
    if (reset) begin
      check_val("rst_level", level, 0);
      check_val("rst_wr_ready", wr_ready, 1);
      check_val("rst_overflow", overflow, 0);
      check_val("rst_tx_req", tx_req, 0);
      check_val("rst_tx_data", tx_data, 0);
      check_val("rst_state", state_dbg, ST_IDLE);
      exp_q.delete();
      ovf_m = 1'b0;
      cr_sent_m = 1'b0;
      last_tx_m = '0;
      prev_ready = 1'b0;
      prev_req = 1'b0;
      last_req_cyc = -100;
    end else begin
      check_val("level", level, exp_q.size());
      check_val("wr_ready", wr_ready, exp_q.size() < DEPTH);
      check_val("overflow", overflow, ovf_m);
      if (int'(level) > max_level) max_level = int'(level);
      full_m = (exp_q.size() == DEPTH);
      if (tx_req) begin
        req_cnt++;
        check_val("req_after_ready", prev_ready, 1);
        check_val("req_single_pulse", prev_req, 0);
        check_val("req_spacing", (cyc - last_req_cyc) >= (2 + GAP), 1);
        check_val("req_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
`ifdef UART_TX_FIFO_CRLF_EN
          if (exp_q[0] == 8'h0A && !cr_sent_m) begin
            e = 8'h0D;
            cr_sent_m = 1'b1;
          end else begin
            e = exp_q.pop_front();
            cr_sent_m = 1'b0;
          end
`else
          e = exp_q.pop_front();
`endif
          check_val("tx_data", tx_data, e);
          last_tx_m = e;
        end
        out_q.push_back(tx_data);
        req_cyc_q.push_back(cyc);
        last_req_cyc = cyc;
      end else begin
        check_val("tx_data_hold", tx_data, last_tx_m);
      end
      if (wr_req) begin
        if (full_m) ovf_m = 1'b1;
        else exp_q.push_back(wr_data);
      end
      prev_ready = tx_ready;
      prev_req = tx_req;
    end
    cyc++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_req = 1'b0;
    uart_auto = 1'b0;
    manual_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    out_q.delete();
    req_cyc_q.delete();
  endtask

  task automatic write_byte(input logic [DW-1:0] b);
    wr_req = 1'b1;
    wr_data = b;
    tick();
    wr_req = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    repeat (4) tick();
    check_val({tag, "_drain_timeout"}, n < budget, 1);
  endtask

  task automatic wait_req(input string tag, input int budget, output bit ok);
    int n = 0;
    while (!tx_req && n < budget) begin
      tick();
      n++;
    end
    ok = (n < budget);
    check_val({tag, "_req_timeout"}, ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wc;
    int accepted;
    int rc;
    int n;
    bit ok;
    logic [DW-1:0] exp6[$];

    // 1: "Hi" with tx_ready high
    do_reset();
    manual_ready = 1'b1;
    wc = cyc;
    write_byte(8'h48);
    write_byte(8'h69);
    wait_drain("t1", 100);
    check_val("t1_count", out_q.size(), 2);
    if (out_q.size() == 2) begin
      check_val("t1_byte0", out_q[0], 8'h48);
      check_val("t1_byte1", out_q[1], 8'h69);
      check_val("t1_latency", req_cyc_q[0] - wc, 2);
      check_val("t1_spacing", (req_cyc_q[1] - req_cyc_q[0]) >= 3, 1);
    end
    check_val("t1_level_end", level, 0);

    // 2: overfill while uart_tx stalled, then release
    do_reset();
    for (int i = 0; i < 17; i++) write_byte(DW'(i));
    check_val("t2_level_full", level, 16);
    check_val("t2_wr_ready", wr_ready, 0);
    check_val("t2_overflow", overflow, 1);
    manual_ready = 1'b1;
    wait_drain("t2", 200);
    check_val("t2_count", out_q.size(), 16);
    for (int i = 0; i < out_q.size(); i++) check_val("t2_order", out_q[i], i);

    // 3: write refused on the cycle a pop frees a slot
    do_reset();
    for (int i = 0; i < 16; i++) write_byte(DW'(8'h20 + i));
    check_val("t3_level_full", level, 16);
    manual_ready = 1'b1;
    wait_req("t3", 20, ok);
    if (ok) begin
      write_byte(8'hAA);
      check_val("t3_level_after", level, 15);
      check_val("t3_overflow", overflow, 1);
      check_val("t3_wr_ready", wr_ready, 1);
    end
    wait_drain("t3", 200);
    check_val("t3_count", out_q.size(), 16);
    if (out_q.size() > 0) check_val("t3_last", out_q[out_q.size() - 1], 8'h2F);

    // 4: random stream through a busy uart_tx model, forcing pointer wrap
    do_reset();
    uart_auto = 1'b1;
    accepted = 0;
    n = 0;
    while (accepted < 40 && n < 3000) begin
      if ($urandom_range(0, 3) != 0) begin
        wr_req = 1'b1;
        wr_data = DW'($urandom);
        if (wr_ready) accepted++;
      end else begin
        wr_req = 1'b0;
      end
      tick();
      n++;
    end
    wr_req = 1'b0;
    check_val("t4_stim_timeout", n < 3000, 1);
    wait_drain("t4", 1000);
    check_val("t4_count", out_q.size(), accepted);
    uart_auto = 1'b0;

    // 5: reset during GAP with five bytes queued
    do_reset();
    for (int i = 0; i < 6; i++) write_byte(DW'(8'h60 + i));
    manual_ready = 1'b1;
    wait_req("t5", 20, ok);
    if (ok) begin
      tick();
      check_val("t5_in_gap", state_dbg, ST_GAP);
      check_val("t5_level_pre", level, 5);
      reset = 1'b1;
      #1;
      check_val("t5_level_rst", level, 0);
      check_val("t5_tx_req_rst", tx_req, 0);
      check_val("t5_overflow_rst", overflow, 0);
      tick();
      reset = 1'b0;
      rc = req_cnt;
      repeat (20) tick();
      check_val("t5_no_reqs", req_cnt - rc, 0);
      check_val("t5_level_end", level, 0);
    end

    // 6: 'A' then LF
    do_reset();
    manual_ready = 1'b1;
    max_level = 0;
    write_byte(8'h41);
    write_byte(8'h0A);
    wait_drain("t6", 100);
`ifdef UART_TX_FIFO_CRLF_EN
    exp6 = '{8'h41, 8'h0D, 8'h0A};
`else
    exp6 = '{8'h41, 8'h0A};
`endif
    check_val("t6_count", out_q.size(), exp6.size());
    for (int i = 0; i < out_q.size() && i < exp6.size(); i++) check_val("t6_seq", out_q[i], exp6[i]);
    check_val("t6_level_peak", max_level, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
